// File: rtl/cnn_job_sequencer.sv
// Host-side job controller for cnn_top: streams operands into the conv/dense BRAMs,
// pulses start, waits for done (with timeout) and returns the class over valid/ready.
module cnn_job_sequencer #(
   parameter int unsigned WORD_W         = 8,
   parameter int unsigned CONV_ADDR_W    = 4,
   parameter int unsigned DENSE_ADDR_W   = 5,
   parameter int unsigned DATA_WORDS     = 8,
   parameter int unsigned CONV_W_WORDS   = 3,
   parameter int unsigned DENSE_W_WORDS  = 18,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_mode,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [WORD_W-1:0]       s_data,
   output logic                    data_bram_wen,
   output logic [CONV_ADDR_W-1:0]  data_bram_addr,
   output logic [WORD_W-1:0]       data_bram_din,
   output logic                    weight_bram_wen,
   output logic [CONV_ADDR_W-1:0]  weight_bram_addr,
   output logic [WORD_W-1:0]       weight_bram_din,
   output logic                    dense_w_bram_wen,
   output logic [DENSE_ADDR_W-1:0] dense_w_bram_addr,
   output logic [WORD_W-1:0]       dense_w_bram_din,
   output logic                    cnn_start,
   input  logic                    cnn_done,
   input  logic [1:0]              cnn_class,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [1:0]              res_class,
   output logic                    res_timeout,
   output logic                    busy
);

   localparam int unsigned CntW = DENSE_ADDR_W;
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      StIdle, StLoadData, StLoadCw, StLoadDw, StDrain, StStart, StWaitDone, StSettle, StResult
   } state_e;

   state_e state_q, state_d;

   logic                    dense_mode_q;
   logic [CntW-1:0]         cnt_q;
   logic [TmoW-1:0]         tmo_q;
   logic                    data_wen_q, weight_wen_q, dense_wen_q;
   logic [CONV_ADDR_W-1:0]  data_addr_q, weight_addr_q;
   logic [DENSE_ADDR_W-1:0] dense_addr_q;
   logic [WORD_W-1:0]       data_din_q, weight_din_q, dense_din_q;
   logic [1:0]              res_class_q;
   logic                    res_timeout_q;

   logic cmd_accept, beat, seg_last, tmo_last;

   assign cmd_accept = cmd_valid & cmd_ready;
   assign beat       = s_valid & s_ready;
   assign tmo_last   = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

   // Last beat of the segment currently being loaded; counter clears here, so it never wraps.
   always_comb begin
      seg_last = 1'b0;
      unique case (state_q)
         StLoadData: seg_last = (cnt_q == CntW'(DATA_WORDS - 1));
         StLoadCw:   seg_last = (cnt_q == CntW'(CONV_W_WORDS - 1));
         StLoadDw:   seg_last = (cnt_q == CntW'(DENSE_W_WORDS - 1));
         default:    ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_accept) begin
               if (cmd_mode[0])      state_d = StLoadData;
               else if (cmd_mode[1]) state_d = StLoadDw;
               else                  state_d = StStart;
            end
         end
         StLoadData: if (beat && seg_last) state_d = StLoadCw;
         StLoadCw:   if (beat && seg_last) state_d = dense_mode_q ? StLoadDw : StDrain;
         StLoadDw:   if (beat && seg_last) state_d = StDrain;
         StDrain:    state_d = StStart;
         StStart:    state_d = StWaitDone;
         StWaitDone: begin
            if (cnn_done)      state_d = StSettle;
            else if (tmo_last) state_d = StResult;
         end
         StSettle:   state_d = StResult;
         StResult:   if (res_ready) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // cmd_ready stays low while reset is still asserted.
   always_comb begin
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      cnn_start = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         StIdle: begin
            cmd_ready = rst_n;
            busy      = 1'b0;
         end
         StLoadData, StLoadCw, StLoadDw: s_ready = 1'b1;
         StStart:  cnn_start = 1'b1;
         StResult: res_valid = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dense_mode_q  <= 1'b0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         data_wen_q    <= 1'b0;
         data_addr_q   <= '0;
         data_din_q    <= '0;
         weight_wen_q  <= 1'b0;
         weight_addr_q <= '0;
         weight_din_q  <= '0;
         dense_wen_q   <= 1'b0;
         dense_addr_q  <= '0;
         dense_din_q   <= '0;
         res_class_q   <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         data_wen_q   <= 1'b0;
         weight_wen_q <= 1'b0;
         dense_wen_q  <= 1'b0;
         if (cmd_accept) begin
            dense_mode_q <= cmd_mode[1];
            cnt_q        <= '0;
         end
         if (beat) begin
            cnt_q <= seg_last ? '0 : cnt_q + 1'b1;
            if (state_q == StLoadData) begin
               data_wen_q  <= 1'b1;
               data_addr_q <= cnt_q[CONV_ADDR_W-1:0];
               data_din_q  <= s_data;
            end else if (state_q == StLoadCw) begin
               weight_wen_q  <= 1'b1;
               weight_addr_q <= cnt_q[CONV_ADDR_W-1:0];
               weight_din_q  <= s_data;
            end else begin
               dense_wen_q  <= 1'b1;
               dense_addr_q <= cnt_q;
               dense_din_q  <= s_data;
            end
         end
         if (state_q == StStart) begin
            tmo_q <= '0;
         end else if (state_q == StWaitDone) begin
            tmo_q <= tmo_q + 1'b1;
         end
         if (state_q == StWaitDone && !cnn_done && tmo_last) begin
            res_timeout_q <= 1'b1;
            res_class_q   <= '0;
         end
         // Class is sampled one cycle after done.
         if (state_q == StSettle) begin
            res_class_q   <= cnn_class;
            res_timeout_q <= 1'b0;
         end
      end
   end

   assign data_bram_wen     = data_wen_q;
   assign data_bram_addr    = data_addr_q;
   assign data_bram_din     = data_din_q;
   assign weight_bram_wen   = weight_wen_q;
   assign weight_bram_addr  = weight_addr_q;
   assign weight_bram_din   = weight_din_q;
   assign dense_w_bram_wen  = dense_wen_q;
   assign dense_w_bram_addr = dense_addr_q;
   assign dense_w_bram_din  = dense_din_q;
   assign res_class         = res_class_q;
   assign res_timeout       = res_timeout_q;

endmodule
